serial_word_loader: RTL and testbench
=====================================

# serial_word_loader

Serial-to-parallel front end for the 32-bit register stage. Collects a framed serial bit stream, LSB first, with an optional even-parity bit. Assembles one word and presents it on `word_out` with a one-cycle `load_en` strobe. `word_out` and `load_en` drive the register's `D` and `enable` inputs directly. The register stage is level-transparent while `clk` is high, so both outputs are registered and held stable for a full clock period.

## Interface
- `WIDTH`, 32, word width in bits. Supported range 2–64; the bit counter is sized to `$clog2(WIDTH)`.
- `PARITY_EN`, 1. When 1, one even-parity bit follows the data bits. When 0, there is no parity phase.
- `clk` input 1 — system clock; every state change happens on its rising edge.
- `rst_n` input 1 — asynchronous, active-low reset.
- `sin_valid` input 1 — `sin_data` / `sin_start` are valid this cycle.
- `sin_data` input 1 — serial data bit.
- `sin_start` input 1 — marks the current bit as bit 0 of a new word.
- `sin_ready` output 1 — loader accepts a bit this cycle.
- `word_out` output WIDTH — assembled word; drives the register `D`.
- `load_en` output 1 — one-cycle load strobe; drives the register `enable`.
- `parity_err` output 1 — one-cycle pulse when a parity check fails.
- `resync` output 1 — one-cycle pulse when a partial word is discarded.
- `busy` output 1 — high in any state other than IDLE.
- `word_count` output 8 — count of successful loads; wraps 255 → 0.

## Operation
- A bit is accepted on a rising edge where `sin_valid && sin_ready`. Without acceptance, no state or datapath change occurs.
- States:
  - **IDLE**: `sin_ready=1`. An accepted bit with `sin_start=1` becomes bit 0, the counter is set to 1, and the FSM goes to SHIFT. Accepted bits with `sin_start=0` are dropped.
  - **SHIFT**: `sin_ready=1`. Each accepted bit is written to `shreg[cnt]`. When `cnt` reaches WIDTH, the FSM goes to PARITY if `PARITY_EN=1`, else to LOAD.
  - **PARITY**: `sin_ready=1`. The accepted bit `p` is checked against ^`shreg`.
    - If `p == ^shreg`, go to LOAD.
    - Otherwise pulse `parity_err` and go to IDLE. `word_out` and `word_count` are unchanged.
  - **LOAD**: `sin_ready=0`, `load_en=1`, `word_out` = new word. The next edge returns to IDLE and increments `word_count`.
- Mid-word resync: an accepted bit with `sin_start=1` in SHIFT or PARITY does the following:
  - pulses `resync`;
  - discards the partial word;
  - treats this bit as the new bit 0 (counter = 1) and goes to SHIFT.
  - In PARITY, `sin_start` takes priority over the parity check.
- `word_out` holds its last loaded value until the next LOAD. It never shows partial data.
- Even parity rule: data bits plus the parity bit contain an even number of ones.

## Timing
- Reset (`rst_n` low, asynchronous) forces:
  - state IDLE, counter 0, `shreg` 0;
  - `word_out` 0, `load_en` 0, `parity_err` 0, `resync` 0, `busy` 0, `word_count` 0;
  - `sin_ready` 1 (IDLE value).
- Reset removal is sampled synchronously. The first acceptance can occur on the first rising edge with `rst_n` high.
- Reset mid-word or during LOAD drops the word with no `load_en`.
- Load latency: the final bit (parity bit, or data bit WIDTH-1 when `PARITY_EN=0`) is accepted at edge N.
  - `load_en` and the new `word_out` rise at N and `load_en` falls at N+1.
  - `word_count` updates at N+1.
- `load_en` covers exactly one full clock period, including the entire high phase of `clk`. `word_out` is stable throughout it and afterward.
- Back-to-back words: `sin_ready` is low only in the LOAD cycle, so the next start bit is accepted at edge N+2 at the earliest.
- `parity_err` and `resync` are registered and last exactly one cycle.
- `busy` = (state != IDLE).
- `sin_valid` gaps of any length are allowed in every state. No timeout applies.

## Test plan
- **Basic load, with gaps**:
  - Stimulus: after reset, send 0xA5A50F0F LSB first with start on bit 0, then parity bit 0. Insert `sin_valid` gaps of 0–3 cycles.
  - Response: `load_en` high for exactly 1 cycle, `word_out`=0xA5A50F0F, `word_count`=1.
- **Parity failure**:
  - Stimulus: send 0x00000001 with parity bit 0.
  - Response: `parity_err` pulses once, no `load_en`, `word_out` keeps its previous value, `word_count` unchanged.
- **Mid-word resync**:
  - Stimulus: send 10 bits of a word, then restart with `sin_start` and send 0x12345678 with parity 1.
  - Response: `resync` pulses at the restart edge, a single `load_en`, `word_out`=0x12345678.
- **Back-to-back**:
  - Stimulus: stream 0xFFFFFFFF (parity 0) and 0x00000000 (parity 0) with `sin_valid` always high.
  - Response: `sin_ready` is low exactly one cycle per word, two `load_en` pulses 34 cycles apart, `word_count`=2.
- **Reset mid-word**:
  - Stimulus: pull `rst_n` low asynchronously (mid-clock-period) after 20 bits.
  - Response: all outputs go to reset values immediately, no `load_en` occurs, and the next full word loads correctly.
- **No parity, counter wrap**:
  - Stimulus: `PARITY_EN=0`, load 256 words.
  - Response: no PARITY phase (33-cycle spacing), `word_count` wraps 255 → 0, last `word_out` matches the last word sent.

Source files
------------

// File: rtl/serial_word_loader_if.sv
// Serial bit-stream handshake between a bit source and serial_word_loader.
// The master drives valid/data/start; the loader answers with ready.
interface serial_word_loader_if;
  logic sin_valid;
  logic sin_data;
  logic sin_start;
  logic sin_ready;

  modport master (
    output sin_valid,
    output sin_data,
    output sin_start,
    input  sin_ready
  );

  modport slave (
    input  sin_valid,
    input  sin_data,
    input  sin_start,
    output sin_ready
  );
endinterface

// File: rtl/serial_word_loader.sv
// Serial-to-parallel word loader: LSB-first framed bits, optional even parity,
// registered word/strobe outputs that stay stable for a whole clock period.
module serial_word_loader #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_word_loader_if.slave  sin,
  output logic [WIDTH-1:0]     word_out,
  output logic                 load_en,
  output logic                 parity_err,
  output logic                 resync,
  output logic                 busy,
  output logic [7:0]           word_count
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StParity, StLoad} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [WIDTH-1:0]  word_q, word_d;
  logic              load_en_q, load_en_d;
  logic              perr_q, perr_d;
  logic              resync_q, resync_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic [7:0]        count_q, count_d;
  logic              accept;

  assign accept = sin.sin_valid && ready_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    word_d    = word_q;
    load_en_d = 1'b0;
    perr_d    = 1'b0;
    resync_d  = 1'b0;
    count_d   = count_q;

    unique case (state_q)
      StIdle: begin
        // Bits without a start marker are dropped while idle.
        if (accept && sin.sin_start) begin
          shreg_d    = '0;
          shreg_d[0] = sin.sin_data;
          cnt_d      = CntW'(1);
          state_d    = StShift;
        end
      end
      StShift: begin
        if (accept) begin
          if (sin.sin_start) begin
            resync_d   = 1'b1;
            shreg_d    = '0;
            shreg_d[0] = sin.sin_data;
            cnt_d      = CntW'(1);
          end else begin
            shreg_d[cnt_q] = sin.sin_data;
            cnt_d          = cnt_q + CntW'(1);
            if (cnt_q == LastIdx) begin
              cnt_d = '0;
              if (PARITY_EN) begin
                state_d = StParity;
              end else begin
                state_d   = StLoad;
                word_d    = shreg_d;
                load_en_d = 1'b1;
              end
            end
          end
        end
      end
      StParity: begin
        if (accept) begin
          // A start marker wins over the parity check.
          if (sin.sin_start) begin
            resync_d   = 1'b1;
            shreg_d    = '0;
            shreg_d[0] = sin.sin_data;
            cnt_d      = CntW'(1);
            state_d    = StShift;
          end else if (sin.sin_data == (^shreg_q)) begin
            state_d   = StLoad;
            word_d    = shreg_q;
            load_en_d = 1'b1;
          end else begin
            perr_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StLoad: begin
        state_d = StIdle;
        count_d = count_q + 8'd1;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    ready_d = (state_d != StLoad);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shreg_q   <= '0;
      word_q    <= '0;
      load_en_q <= 1'b0;
      perr_q    <= 1'b0;
      resync_q  <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      word_q    <= word_d;
      load_en_q <= load_en_d;
      perr_q    <= perr_d;
      resync_q  <= resync_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      count_q   <= count_d;
    end
  end

  assign sin.sin_ready = ready_q;
  assign word_out      = word_q;
  assign load_en       = load_en_q;
  assign parity_err    = perr_q;
  assign resync        = resync_q;
  assign busy          = busy_q;
  assign word_count    = count_q;

endmodule

// File: tb/tb_serial_word_loader.sv
// Bench for serial_word_loader: a parity and a no-parity instance, frame-level
// reference model feeding per-instance event queues, checked by a monitor.
module tb_serial_word_loader;

  localparam logic [1:0] EvLoad = 2'd0, EvPerr = 2'd1, EvResync = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] word;
  } ev_t;

  logic clk, rst_n;
  serial_word_loader_if sif0 ();
  serial_word_loader_if sif1 ();

  logic [31:0] wo0, wo1;
  logic        le0, le1, pe0, pe1, rs0, rs1, busy0, busy1;
  logic [7:0]  wc0, wc1;

  serial_word_loader #(.WIDTH(32), .PARITY_EN(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .sin(sif0), .word_out(wo0), .load_en(le0),
    .parity_err(pe0), .resync(rs0), .busy(busy0), .word_count(wc0)
  );

  serial_word_loader #(.WIDTH(32), .PARITY_EN(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sin(sif1), .word_out(wo1), .load_en(le1),
    .parity_err(pe1), .resync(rs1), .busy(busy1), .word_count(wc1)
  );

  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc      = 0;
  ev_t         q0[$];
  ev_t         q1[$];
  logic [7:0]  mcount[2]    = '{8'd0, 8'd0};
  logic [31:0] mlast[2]     = '{32'd0, 32'd0};
  int          last_load[2] = '{0, 0};
  int          prev_load[2] = '{0, 0};
  bit          partial[2]   = '{1'b0, 1'b0};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(input int idx, input logic [1:0] k, input logic [31:0] w);
    ev_t e;
    e.kind = k;
    e.word = w;
    if (idx == 0) q0.push_back(e);
    else          q1.push_back(e);
  endtask

  // Per-cycle observation of one instance against the model state.
  task automatic mon(input int idx, input logic [31:0] wo, input logic le, input logic pe,
                     input logic rs, input logic rdy, input logic [7:0] wc);
    ev_t  e;
    logic have;
    chk($sformatf("dut%0d word_count", idx), 64'(wc), 64'(mcount[idx]));
    chk($sformatf("dut%0d ready_vs_load", idx), 64'(rdy), 64'(!le));
    if (le || pe || rs) begin
      chk($sformatf("dut%0d single_pulse", idx), 64'(int'(le) + int'(pe) + int'(rs)), 64'd1);
      have = (idx == 0) ? (q0.size() > 0) : (q1.size() > 0);
      n_checks++;
      if (!have) begin
        n_err++;
        $display("FAIL dut%0d unexpected_pulse: got le=%0b pe=%0b rs=%0b expected none",
                 idx, le, pe, rs);
      end else begin
        e = (idx == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("dut%0d event_kind", idx),
            64'(le ? EvLoad : (pe ? EvPerr : EvResync)), 64'(e.kind));
        if (le && e.kind == EvLoad) mlast[idx] = e.word;
      end
    end
    chk($sformatf("dut%0d word_out", idx), 64'(wo), 64'(mlast[idx]));
    if (le) begin
      mcount[idx]    = mcount[idx] + 8'd1;
      prev_load[idx] = last_load[idx];
      last_load[idx] = cyc;
    end
  endtask

  always @(negedge clk) begin
    mon(0, wo0, le0, pe0, rs0, sif0.sin_ready, wc0);
    mon(1, wo1, le1, pe1, rs1, sif1.sin_ready, wc1);
  end

  function automatic logic rdy(input int idx);
    return (idx == 0) ? sif0.sin_ready : sif1.sin_ready;
  endfunction

  task automatic drive(input int idx, input logic v, input logic d, input logic s);
    if (idx == 0) begin
      sif0.sin_valid = v; sif0.sin_data = d; sif0.sin_start = s;
    end else begin
      sif1.sin_valid = v; sif1.sin_data = d; sif1.sin_start = s;
    end
  endtask

  // Entered and left at a falling edge; the bit is accepted on the rising edge between.
  task automatic send_bit(input int idx, input logic d, input logic s, input int gapmax);
    int gap;
    int w;
    gap = $urandom_range(0, gapmax);
    for (int k = 0; k < gap; k++) begin
      drive(idx, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
    end
    drive(idx, 1'b1, d, s);
    w = 0;
    while (!rdy(idx)) begin
      @(negedge clk);
      w++;
      if (w > 8) begin
        n_checks++;
        n_err++;
        $display("FAIL dut%0d ready_timeout: got ready=0 for %0d cycles expected ready", idx, w);
        break;
      end
    end
    @(negedge clk);
    drive(idx, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input int idx, input logic [31:0] w, input logic p, input int gapmax);
    int ones;
    if (partial[idx]) push(idx, EvResync, 32'd0);
    partial[idx] = 1'b0;
    ones = $countones(w) + int'(p);
    if (idx == 1 || (ones % 2) == 0) push(idx, EvLoad, w);
    else                             push(idx, EvPerr, 32'd0);
    for (int i = 0; i < 32; i++) send_bit(idx, w[i], (i == 0), gapmax);
    if (idx == 0) send_bit(idx, p, 1'b0, gapmax);
  endtask

  task automatic send_partial(input int idx, input logic [31:0] w, input int n, input int gapmax);
    if (partial[idx]) push(idx, EvResync, 32'd0);
    for (int i = 0; i < n; i++) send_bit(idx, w[i], (i == 0), gapmax);
    partial[idx] = (n > 0);
  endtask

  task automatic reset_model();
    for (int i = 0; i < 2; i++) begin
      mcount[i]  = 8'd0;
      mlast[i]   = 32'd0;
      partial[i] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic check_reset_values(input int idx);
    logic [31:0] wo;
    logic        le, pe, rs, b, r;
    logic [7:0]  wc;
    wo = idx == 0 ? wo0 : wo1;      le = idx == 0 ? le0 : le1;
    pe = idx == 0 ? pe0 : pe1;      rs = idx == 0 ? rs0 : rs1;
    b  = idx == 0 ? busy0 : busy1;  wc = idx == 0 ? wc0 : wc1;
    r  = rdy(idx);
    chk($sformatf("dut%0d rst word_out", idx), 64'(wo), 64'd0);
    chk($sformatf("dut%0d rst load_en", idx), 64'(le), 64'd0);
    chk($sformatf("dut%0d rst parity_err", idx), 64'(pe), 64'd0);
    chk($sformatf("dut%0d rst resync", idx), 64'(rs), 64'd0);
    chk($sformatf("dut%0d rst busy", idx), 64'(b), 64'd0);
    chk($sformatf("dut%0d rst word_count", idx), 64'(wc), 64'd0);
    chk($sformatf("dut%0d rst sin_ready", idx), 64'(r), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic        p;
    int          r;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check_reset_values(0);
    check_reset_values(1);
    rst_n = 1'b1;

    // Basic load with gaps.
    send_frame(0, 32'hA5A5_0F0F, 1'b0, 3);
    repeat (3) @(negedge clk);
    chk("basic word_out", 64'(wo0), 64'hA5A5_0F0F);
    chk("basic word_count", 64'(wc0), 64'd1);

    // Parity failure keeps the previous word.
    send_frame(0, 32'h0000_0001, 1'b0, 2);
    repeat (3) @(negedge clk);
    chk("perr word_out", 64'(wo0), 64'hA5A5_0F0F);
    chk("perr word_count", 64'(wc0), 64'd1);

    // Mid-word resync.
    send_partial(0, $urandom, 10, 3);
    send_frame(0, 32'h1234_5678, 1'b1, 2);
    repeat (3) @(negedge clk);
    chk("resync word_out", 64'(wo0), 64'h1234_5678);
    chk("resync word_count", 64'(wc0), 64'd2);

    // Back-to-back with valid held high.
    send_frame(0, 32'hFFFF_FFFF, 1'b0, 0);
    send_frame(0, 32'h0000_0000, 1'b0, 0);
    repeat (3) @(negedge clk);
    chk("b2b spacing", 64'(last_load[0] - prev_load[0]), 64'd34);
    chk("b2b word_count", 64'(wc0), 64'd4);

    // Randomized mix: idle junk, partial words (incl. into parity phase), good/bad parity.
    for (int it = 0; it < 30; it++) begin
      r = $urandom_range(0, 9);
      w = $urandom;
      if (r < 2 && !partial[0]) begin
        for (int k = 0; k < 3; k++) send_bit(0, 1'($urandom), 1'b0, 2);
      end else if (r < 4) begin
        send_partial(0, w, $urandom_range(1, 32), 2);
      end else begin
        p = (^w) ^ ($urandom_range(0, 3) == 0);
        send_frame(0, w, p, 2);
      end
    end
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-word, then a clean load.
    send_partial(0, $urandom, 20, 1);
    chk("midword busy", 64'(busy0), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values(0);
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(0, 32'hC0DE_1234, ^32'hC0DE_1234, 1);
    repeat (3) @(negedge clk);
    chk("post-reset word_out", 64'(wo0), 64'hC0DE_1234);
    chk("post-reset word_count", 64'(wc0), 64'd1);

    // No-parity instance: 256 streamed words, count wraps to zero.
    for (int i = 0; i < 256; i++) begin
      w = (i == 255) ? 32'h5EED_F00D : $urandom;
      send_frame(1, w, 1'b0, 0);
    end
    repeat (3) @(negedge clk);
    chk("nopar spacing", 64'(last_load[1] - prev_load[1]), 64'd33);
    chk("nopar wrap word_count", 64'(wc1), 64'd0);
    chk("nopar last word_out", 64'(wo1), 64'h5EED_F00D);

    repeat (5) @(negedge clk);
    chk("dut0 queue drained", 64'(q0.size()), 64'd0);
    chk("dut1 queue drained", 64'(q1.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
